// File: rtl/adc_cfg_pkg.sv
// Shared types, default sizes and helpers for the ADC configuration serializer.
package adc_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_GAP
  } state_e;

  localparam int unsigned DEF_WORD_W  = 16;
  localparam int unsigned DEF_NUM_CH  = 4;
  localparam int unsigned DEF_CLK_DIV = 2;
  localparam int unsigned DEF_GAP     = 2;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_cfg_serializer_sclk_div.sv
// SCLK phase divider: phase_tick marks the last clk cycle of each CLK_DIV-long phase.
module adc_sclk_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic phase_tick
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt;

  assign phase_tick = en && (cnt == CNT_W'(CLK_DIV - 1));

  // Restart on every phase boundary so each phase is exactly CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en || clr || phase_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_cfg_serializer.sv
// Serializes one control word to one ADC (or all of them) over SCLK/SDATA with
// per-channel active-low frame sync; every output is registered.
module adc_cfg_serializer
  import adc_cfg_pkg::*;
#(
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned GAP       = DEF_GAP,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CH_W     = sel_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              bcast,
  input  logic [CH_W-1:0]   ch_sel,
  input  logic [WORD_W-1:0] word_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              SCLK,
  output logic [NUM_CH-1:0] TFSnot,
  output logic              SDATA
);

  localparam int unsigned BC_W = $clog2(WORD_W + 1);
  localparam int unsigned GC_W = 8;

  state_e            state, state_nxt;
  logic [WORD_W-1:0] shreg, shreg_nxt;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [GC_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic              busy_nxt, done_nxt, err_nxt, sclk_nxt, sdata_nxt;
  logic [NUM_CH-1:0] tfs_nxt;
  logic              div_en, div_clr, phase_tick;

  function automatic logic lead_bit(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? w[WORD_W-1] : w[0];
  endfunction

  function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? {w[WORD_W-2:0], 1'b0} : {1'b0, w[WORD_W-1:1]};
  endfunction

  assign div_en  = (state == ST_SETUP) || (state == ST_LOW) || (state == ST_HIGH);
  assign div_clr = (state_nxt != state);

  adc_sclk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .en         (div_en),
    .clr        (div_clr),
    .phase_tick (phase_tick)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      SCLK    <= 1'b1;
      TFSnot  <= '1;
      SDATA   <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bit_cnt <= bit_cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      err     <= err_nxt;
      SCLK    <= sclk_nxt;
      TFSnot  <= tfs_nxt;
      SDATA   <= sdata_nxt;
    end
  end

  // Next state and next output values; outputs change only on phase entry.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    gap_cnt_nxt = gap_cnt;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    sclk_nxt    = SCLK;
    tfs_nxt     = TFSnot;
    sdata_nxt   = SDATA;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (!bcast && (32'(ch_sel) >= NUM_CH)) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt   = ST_SETUP;
            busy_nxt    = 1'b1;
            shreg_nxt   = word_in;
            bit_cnt_nxt = '0;
            sclk_nxt    = 1'b1;
            tfs_nxt     = bcast ? '0 : ~(NUM_CH'(1) << ch_sel);
            sdata_nxt   = lead_bit(word_in);
          end
        end
      end
      ST_SETUP: begin
        if (phase_tick) begin
          state_nxt = ST_LOW;
          sclk_nxt  = 1'b0;
        end
      end
      ST_LOW: begin
        if (phase_tick) begin
          sclk_nxt = 1'b1;
          if (bit_cnt == BC_W'(WORD_W - 1)) begin
            state_nxt   = ST_GAP;
            tfs_nxt     = '1;
            sdata_nxt   = 1'b0;
            gap_cnt_nxt = '0;
          end else begin
            state_nxt   = ST_HIGH;
            bit_cnt_nxt = bit_cnt + BC_W'(1);
            shreg_nxt   = advance(shreg);
            sdata_nxt   = lead_bit(advance(shreg));
          end
        end
      end
      ST_HIGH: begin
        if (phase_tick) begin
          state_nxt = ST_LOW;
          sclk_nxt  = 1'b0;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GC_W'(GAP - 1)) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt + GC_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_cfg_serializer.sv
// Bench for adc_cfg_serializer: defaults, a 3-channel variant and an LSB-first CLK_DIV=1 variant.
module tb_adc_cfg_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic a_start, a_bcast, a_busy, a_done, a_err, a_sclk, a_sdata;
  logic [1:0]  a_ch;
  logic [15:0] a_word;
  logic [3:0]  a_tfs;

  logic b_start, b_bcast, b_busy, b_done, b_err, b_sclk, b_sdata;
  logic [1:0]  b_ch;
  logic [15:0] b_word;
  logic [2:0]  b_tfs;

  logic c_start, c_bcast, c_busy, c_done, c_err, c_sclk, c_sdata;
  logic [1:0]  c_ch;
  logic [15:0] c_word;
  logic [3:0]  c_tfs;

  int total = 0;
  int bad   = 0;

  adc_cfg_serializer u_a (
    .clk(clk), .reset(reset), .start(a_start), .bcast(a_bcast), .ch_sel(a_ch),
    .word_in(a_word), .busy(a_busy), .done(a_done), .err(a_err),
    .SCLK(a_sclk), .TFSnot(a_tfs), .SDATA(a_sdata)
  );

  adc_cfg_serializer #(.NUM_CH(3)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .bcast(b_bcast), .ch_sel(b_ch),
    .word_in(b_word), .busy(b_busy), .done(b_done), .err(b_err),
    .SCLK(b_sclk), .TFSnot(b_tfs), .SDATA(b_sdata)
  );

  adc_cfg_serializer #(.MSB_FIRST(1'b0), .CLK_DIV(1)) u_c (
    .clk(clk), .reset(reset), .start(c_start), .bcast(c_bcast), .ch_sel(c_ch),
    .word_in(c_word), .busy(c_busy), .done(c_done), .err(c_err),
    .SCLK(c_sclk), .TFSnot(c_tfs), .SDATA(c_sdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic s, input logic [15:0] w,
                       input logic bc, input logic [1:0] ch);
    if (d == 0) begin
      a_start = s; a_word = w; a_bcast = bc; a_ch = ch;
    end else begin
      c_start = s; c_word = w; c_bcast = bc; c_ch = ch;
    end
  endtask

  task automatic peek(input int d, output logic sclk, output logic sdata, output logic busy,
                      output logic done, output logic err, output logic [3:0] tfs);
    if (d == 0) begin
      sclk = a_sclk; sdata = a_sdata; busy = a_busy; done = a_done; err = a_err; tfs = a_tfs;
    end else begin
      sclk = c_sclk; sdata = c_sdata; busy = c_busy; done = c_done; err = c_err; tfs = c_tfs;
    end
  endtask

  // One frame on DUT a (d=0) or c (d=2). Called on a negedge with the DUT idle or showing done;
  // returns on the negedge where done is visible so a following call lands on the done cycle.
  task automatic run_frame(input string tag, input int d, input logic [15:0] w,
                           input logic bc, input logic [1:0] ch, input int poke_at);
    int div, flen, span, falls, tfs_bad, busy_bad, done_bad, err_bad;
    bit msb;
    logic prev, sclk, sdata, busy, done, err;
    logic [3:0] tfs, exp_tfs;
    logic [15:0] got, want;
    div  = (d == 0) ? 2 : 1;
    msb  = (d == 0);
    flen = 2 * 16 * div;
    span = flen + 2;
    exp_tfs = bc ? 4'b0000 : ~(4'b0001 << ch);
    for (int i = 0; i < 16; i++) want[i] = msb ? w[15-i] : w[i];
    got = '0;
    falls = 0; tfs_bad = 0; busy_bad = 0; done_bad = 0; err_bad = 0;
    prev = 1'b1;
    drive(d, 1'b1, w, bc, ch);
    for (int k = 1; k <= span + 1; k++) begin
      @(negedge clk);
      drive(d, (k == poke_at), 16'($urandom), 1'($urandom), 2'($urandom));
      peek(d, sclk, sdata, busy, done, err, tfs);
      if (prev && !sclk) begin
        if (falls < 16) got[falls] = sdata;
        falls++;
      end
      prev = sclk;
      if (tfs !== ((k <= flen) ? exp_tfs : 4'hF)) tfs_bad++;
      if (busy !== (k <= span)) busy_bad++;
      if (done !== (k == span + 1)) done_bad++;
      if (err !== 1'b0) err_bad++;
    end
    chk({tag, "_falls"}, 32'(falls), 32'd16);
    chk({tag, "_bits"}, 32'(got), 32'(want));
    chk({tag, "_tfs_bad_cycles"}, 32'(tfs_bad), 32'd0);
    chk({tag, "_busy_bad_cycles"}, 32'(busy_bad), 32'd0);
    chk({tag, "_done_bad_cycles"}, 32'(done_bad), 32'd0);
    chk({tag, "_err_bad_cycles"}, 32'(err_bad), 32'd0);
  endtask

  initial begin
    int falls, dk, cnt_done, cnt_busy, cnt_low;
    logic prev;

    reset = 1'b1;
    a_start = 0; a_bcast = 0; a_ch = 0; a_word = 0;
    b_start = 0; b_bcast = 0; b_ch = 0; b_word = 0;
    c_start = 0; c_bcast = 0; c_ch = 0; c_word = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("a_rst_sclk", 32'(a_sclk), 32'd1);
    chk("a_rst_tfs", 32'(a_tfs), 32'hF);
    chk("a_rst_flags", {29'd0, a_busy, a_done, a_err}, 32'd0);
    chk("a_rst_sdata", 32'(a_sdata), 32'd0);
    chk("b_rst_tfs", 32'(b_tfs), 32'h7);
    chk("c_rst_tfs", 32'(c_tfs), 32'hF);
    @(negedge clk);

    // Directed frames on the default instance
    run_frame("a5c3", 0, 16'hA5C3, 1'b0, 2'd2, 0);
    @(negedge clk);
    run_frame("bcast0001", 0, 16'h0001, 1'b1, 2'd0, 0);
    @(negedge clk);
    run_frame("poke10", 0, 16'h3C5A, 1'b0, 2'd1, 10);
    run_frame("chained", 0, 16'hF00D, 1'b0, 2'd3, 0);

    // Randomized frames, some back-to-back, with stray start pulses mid-frame
    for (int r = 0; r < 4; r++) begin
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      run_frame($sformatf("rnd%0d", r), 0, 16'($urandom), ($urandom_range(0, 3) == 0),
                2'($urandom), int'($urandom_range(1, 62)));
    end
    @(negedge clk);

    // Reset after the 5th falling edge
    a_start = 1'b1; a_word = 16'hFFFF; a_bcast = 1'b0; a_ch = 2'd0;
    falls = 0; prev = 1'b1;
    for (int k = 0; k < 40 && falls < 5; k++) begin
      @(negedge clk);
      a_start = 1'b0;
      if (prev && !a_sclk) falls++;
      prev = a_sclk;
    end
    chk("rst_mid_reached", 32'(falls), 32'd5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_sclk", 32'(a_sclk), 32'd1);
    chk("rst_mid_tfs", 32'(a_tfs), 32'hF);
    chk("rst_mid_busy", 32'(a_busy), 32'd0);
    chk("rst_mid_sdata", 32'(a_sdata), 32'd0);
    cnt_done = 0; cnt_busy = 0; cnt_low = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      cnt_done += int'(a_done);
      cnt_busy += int'(a_busy);
      cnt_low  += int'(!a_sclk) + int'(a_tfs != 4'hF);
    end
    chk("rst_mid_no_done", 32'(cnt_done), 32'd0);
    chk("rst_mid_no_resume", 32'(cnt_busy + cnt_low), 32'd0);

    // Reset wins over a coincident start
    reset = 1'b1; a_start = 1'b1; a_word = 16'h1234;
    @(negedge clk);
    reset = 1'b0; a_start = 1'b0;
    chk("rst_prio_busy0", 32'(a_busy), 32'd0);
    @(negedge clk);
    chk("rst_prio_busy1", 32'(a_busy), 32'd0);

    // Three-channel instance: out-of-range select rejected, broadcast accepted
    b_start = 1'b1; b_bcast = 1'b0; b_ch = 2'd3; b_word = 16'($urandom);
    @(negedge clk);
    b_start = 1'b0;
    chk("b_err_pulse", 32'(b_err), 32'd1);
    chk("b_err_idle", {29'd0, b_busy, b_sclk, b_done}, 32'h2);
    chk("b_err_tfs", 32'(b_tfs), 32'h7);
    @(negedge clk);
    chk("b_err_one_cycle", 32'(b_err), 32'd0);
    b_start = 1'b1; b_bcast = 1'b0; b_ch = 2'd2; b_word = 16'h00FF;
    @(negedge clk);
    b_start = 1'b0;
    chk("b_ch2_busy", 32'(b_busy), 32'd1);
    chk("b_ch2_tfs", 32'(b_tfs), 32'h3);
    dk = 0;
    for (int k = 2; k <= 100 && dk == 0; k++) begin
      @(negedge clk);
      if (b_done) dk = k;
    end
    chk("b_ch2_done_at", 32'(dk), 32'd67);
    b_start = 1'b1; b_bcast = 1'b1; b_ch = 2'd3;
    @(negedge clk);
    b_start = 1'b0;
    chk("b_bcast_no_err", 32'(b_err), 32'd0);
    chk("b_bcast_tfs", 32'(b_tfs), 32'h0);

    // LSB-first, CLK_DIV=1 instance
    run_frame("lsb8000", 2, 16'h8000, 1'b0, 2'd0, 0);
    run_frame("lsbrnd", 2, 16'($urandom), 1'b0, 2'($urandom), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
